spart_bus_ctrl: RTL

Bus-sequencing controller for the SPART. It owns the SPART processor-side bus (iocs/iorw/ioaddr/databus) and programs the baud divisor from `br_cfg` after reset. It then runs a poll/read/write loop that echoes every received byte back to the transmitter through a one-byte holding buffer. It sits beside `spart_DUT` in the top level and replaces ad-hoc bus driving.

---
 rtl/spart_pkg.sv | 31 +++
 rtl/spart_bus_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/spart_pkg.sv
// Shared SPART controller types: FSM state encoding, bus register addresses, baud divisors.
// Latency: none (definitions only).
// Backpressure: not applicable.
package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        POLL,
        RD,
        WR
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // System-clock counts per baud tick for each br_cfg setting
    function automatic logic [15:0] br_div(input logic [1:0] cfg);
        logic [15:0] d;
        case (cfg)
            2'b00:   d = 16'h0412;
            2'b01:   d = 16'h0209;
            2'b10:   d = 16'h0104;
            default: d = 16'h0082;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/spart_bus_ctrl.sv
// SPART bus sequencer: programs the divisor, then echoes each received byte via a 1-byte buffer.
// Latency: divisor written in cycles 0-1 after reset; echo RD at n+1, WR at n+3 after rda seen in POLL.
// Backpressure: tbr low holds the buffered byte; rda is ignored until the buffer drains (SPART holds rda).
// Optional: SPART_CTRL_RECONFIG_EN re-runs the divisor write when br_cfg changes while in POLL.
module spart_bus_ctrl
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       cfg_done
);

    state_t      state;
    logic [1:0]  cfg_q;
    logic [7:0]  hold_buf;
    logic        buf_full;
    logic [7:0]  dout;
    logic [15:0] div_cur;
    logic [15:0] div_lat;

    // Low byte comes straight from br_cfg (latched at the end of CFG_LO); high byte from the latched copy
    assign div_cur = br_div(br_cfg);
    assign div_lat = br_div(cfg_q);

    // Bus is driven only for write cycles and never while reset is asserted
    assign databus = (rst && (state == WR || state == CFG_LO || state == CFG_HI)) ? dout : 8'hzz;

    // Sequencer: divisor programming, then poll/read/write echo loop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CFG_LO;
            cfg_q    <= 2'b00;
            hold_buf <= 8'h00;
            buf_full <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                CFG_LO: begin
                    cfg_q <= br_cfg;
                    state <= CFG_HI;
                end
                CFG_HI: begin
                    cfg_done <= 1'b1;
                    state    <= POLL;
                end
                POLL: begin
`ifdef SPART_CTRL_RECONFIG_EN
                    if (br_cfg != cfg_q) begin
                        cfg_done <= 1'b0;
                        state    <= CFG_LO;
                    end else
`endif
                    if (buf_full && tbr) begin
                        state <= WR;
                    end else if (rda && !buf_full) begin
                        state <= RD;
                    end
                end
                RD: begin
                    hold_buf <= databus;
                    rx_data  <= databus;
                    buf_full <= 1'b1;
                    rx_valid <= 1'b1;
                    state    <= POLL;
                end
                WR: begin
                    buf_full <= 1'b0;
                    state    <= POLL;
                end
                default: state <= CFG_LO;
            endcase
        end
    end

    // Bus control decode from state; forced to idle values while reset is asserted
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = ADDR_DATA;
        dout   = 8'h00;
        if (rst) begin
            case (state)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DBL;
                    dout   = div_cur[7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DBH;
                    dout   = div_lat[15:8];
                end
                RD: begin
                    iocs   = 1'b1;
                    iorw   = 1'b1;
                    ioaddr = ADDR_DATA;
                end
                WR: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DATA;
                    dout   = hold_buf;
                end
                default: begin
                    iocs = 1'b0;
                end
            endcase
        end
    end

endmodule
